// File: rtl/wb_sequencer_if.sv
// Write-back sequencer bus. It groups the request queue inputs, the per-source
// ready flags, and the MemtoReg / register-file outputs with their status flags.
//   master: request producer (control unit side); drives requests and src_ready
//   slave : the sequencer; drives wb_ready, mux select, write port and status
interface wb_sequencer_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          wb_valid;
  logic          wb_ready;
  logic [3:0]    wb_sel;
  logic [4:0]    wb_rd;
  logic [7:0]    src_ready;
  logic [3:0]    MemtoReg;
  logic [4:0]    WriteReg;
  logic          RegWrite;
  logic          illegal_sel;
  logic          timeout;
  logic          busy;
  logic [CW-1:0] count;

  modport master (
    output wb_valid, wb_sel, wb_rd, src_ready,
    input  wb_ready, MemtoReg, WriteReg, RegWrite, illegal_sel, timeout, busy, count
  );

  modport slave (
    input  wb_valid, wb_sel, wb_rd, src_ready,
    output wb_ready, MemtoReg, WriteReg, RegWrite, illegal_sel, timeout, busy, count
  );
endinterface

// File: rtl/wb_sequencer.sv
// Register-file write-back sequencer. It queues {sel, rd} requests in a circular
// FIFO and pops one at a time. It drives MemtoReg/WriteReg one cycle before
// RegWrite so the write-back mux can settle, and it waits in SETUP for the
// selected source to report ready.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : wb_sequencer_if.slave (request handshake, src_ready, write port, status)
module wb_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic           clk,
  input  logic           reset,
  wb_sequencer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cur_sel_q, cur_sel_d;
  logic [4:0]    cur_rd_q, cur_rd_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    memto_q, memto_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic          reg_write_q, reg_write_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic          wb_ready_q, wb_ready_d;
  logic          busy_q, busy_d;
  logic          push, pop;

  logic [3:0] sel_mem [DEPTH];
  logic [4:0] rd_mem  [DEPTH];

  // Payload storage; validity is tracked by the pointers and count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr_q] <= bus.wb_sel;
      rd_mem[wr_ptr_q]  <= bus.wb_rd;
    end
  end

  // Next-state logic for the FSM, the FIFO pointers and the registered outputs.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cur_sel_d   = cur_sel_q;
    cur_rd_d    = cur_rd_q;
    wait_d      = wait_q;
    memto_d     = memto_q;
    write_reg_d = write_reg_q;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    timeout_d   = 1'b0;
    push        = bus.wb_valid && wb_ready_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          cur_sel_d   = sel_mem[rd_ptr_q];
          cur_rd_d    = rd_mem[rd_ptr_q];
          memto_d     = sel_mem[rd_ptr_q];
          write_reg_d = rd_mem[rd_ptr_q];
          wait_d      = '0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cur_sel_q >= 4'd12) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cur_sel_q[3] || bus.src_ready[cur_sel_q[2:0]]) begin
          // Codes 8..11 are constants and always ready; $zero is never written.
          state_d     = S_WRITE;
          reg_write_d = (cur_rd_q != 5'd0);
        end else if (wait_q == WW'(MAX_WAIT)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    wb_ready_d = (count_d != CW'(DEPTH));
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_sel_q   <= '0;
      cur_rd_q    <= '0;
      wait_q      <= '0;
      memto_q     <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      wb_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_sel_q   <= cur_sel_d;
      cur_rd_q    <= cur_rd_d;
      wait_q      <= wait_d;
      memto_q     <= memto_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      wb_ready_q  <= wb_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.wb_ready    = wb_ready_q;
  assign bus.MemtoReg    = memto_q;
  assign bus.WriteReg    = write_reg_q;
  assign bus.RegWrite    = reg_write_q;
  assign bus.illegal_sel = illegal_q;
  assign bus.timeout     = timeout_q;
  assign bus.busy        = busy_q;
  assign bus.count       = count_q;
endmodule
